fb_buf_sched: RTL
=================

FB_BUF_SCHED -- requirements
Module: fb_buf_sched

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 32: frame buffer address width.
REQ-002 SHALL have parameter C_BUF_NUM, default 3: number of frame buffers; legal range 3..4.
REQ-003 SHALL have parameter C_IDX_BITS, default 2: buffer index width.
REQ-004 SHALL have parameter C_CNT_BITS, default 16: statistics counter width.
REQ-005 SHALL have port clk, input, 1: single clock.
REQ-006 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port soft_resetn, input, 1: synchronous active-low scheduler restart.
REQ-008 SHALL have port resetting, output, 1: high while the block is not in RUN.
REQ-009 SHALL have port buf_addr, input, C_BUF_NUM*C_ADDR_WIDTH: base addresses; buffer k occupies slice k.
REQ-010 SHALL have port s2mm_sof, input, 1: writer frame-start pulse.
REQ-011 SHALL have ports s2mm_idx and s2mm_addr, outputs, C_IDX_BITS and C_ADDR_WIDTH: the buffer the writer fills.
REQ-012 SHALL have port mm2s_sof, input, 1: reader frame-start pulse.
REQ-013 SHALL have ports mm2s_idx, mm2s_addr and mm2s_valid, outputs, C_IDX_BITS, C_ADDR_WIDTH and 1: the buffer the reader holds.
REQ-014 SHALL have ports wr_frame_cnt, drop_cnt and repeat_cnt, outputs, C_CNT_BITS each: frame statistics.

Function
REQ-015 SHALL implement states IDLE and RUN; IDLE->RUN on s2mm_sof; any state->IDLE one cycle after soft_resetn is sampled low.
REQ-016 SHALL keep w_idx, r_idx, latest, latest_valid, consumed and mm2s_valid; all address outputs are registered from buf_addr[idx], one cycle after the index changes.
REQ-017 SHALL, on IDLE->RUN, keep w_idx=0 and publish nothing.
REQ-018 SHALL, on s2mm_sof in RUN, set latest<=w_idx, latest_valid<=1, consumed<=0, and w_idx<=next.
REQ-019 SHALL compute next as (w_idx+1) mod C_BUF_NUM, stepped once more when it equals the reader's effective index.
REQ-020 SHALL define the reader's effective index as the new r_idx when mm2s_sof is in the same cycle, otherwise the current r_idx.
REQ-021 SHALL, on mm2s_sof with latest_valid=1, set r_idx<=latest, mm2s_valid<=1 and consumed<=1; with latest_valid=0, mm2s_sof is ignored.
REQ-022 SHALL, on simultaneous pulses, give the reader the pre-update latest, so w_idx never equals r_idx while mm2s_valid=1.
REQ-023 SHALL increment wr_frame_cnt on every s2mm_sof in RUN.
REQ-024 SHALL increment drop_cnt on s2mm_sof in RUN when latest_valid=1 and consumed=0, unless mm2s_sof occurs in the same cycle.
REQ-025 SHALL increment repeat_cnt on mm2s_sof when mm2s_valid=1 and latest==r_idx.
REQ-026 SHALL saturate all counters at all-ones.
REQ-027 SHALL, when soft_resetn goes low mid-frame, clear indices, latest_valid, consumed and mm2s_valid, and hold the counters.

Reset
REQ-028 SHALL, on resetn low, immediately set: state=IDLE, all indices 0, latest_valid=0, consumed=0, mm2s_valid=0, address outputs 0, counters 0, resetting=1.

Configuration
REQ-029 SHALL, with FB_SCHED_STATS_EN defined, implement wr_frame_cnt, drop_cnt and repeat_cnt as specified.
REQ-030 SHALL, without FB_SCHED_STATS_EN, tie the three counter outputs to 0 and implement no counter logic.

Structure
REQ-031 SHALL place the state encoding (IDLE, RUN) and the default parameter constants in shared package fb_sched_pkg.
REQ-032 SHALL implement next-index selection in combinational sub-module fb_next_idx (inputs w_idx and effective reader index, output next).

Verification (C_BUF_NUM=3, buf_addr = 0x1000_0000, 0x1010_0000, 0x1020_0000)
REQ-033 SHALL cover: release resetn, pulse s2mm_sof -> resetting=0, s2mm_addr=0x1000_0000, mm2s_valid=0.
REQ-034 SHALL cover: second s2mm_sof, then mm2s_sof -> s2mm_idx=1, mm2s_idx=0, mm2s_addr=0x1000_0000, mm2s_valid=1.
REQ-035 SHALL cover: reader holds 0, two more s2mm_sof without mm2s_sof -> latest=2, w_idx=1 (0 skipped), drop_cnt=1.
REQ-036 SHALL cover: simultaneous s2mm_sof and mm2s_sof with w_idx=1, latest=0, r_idx=2 -> r_idx=0, latest=1, w_idx=2, drop_cnt unchanged.
REQ-037 SHALL cover: soft_resetn low for 1 cycle mid-frame -> IDLE next cycle, all indices 0, mm2s_valid=0, counters held.
REQ-038 SHALL cover: build without FB_SCHED_STATS_EN and repeat the REQ-035 scenario -> all counter outputs 0.

Source files
------------

// File: rtl/fb_sched_pkg.sv
// Shared types and default constants for the frame-buffer scheduler.
`timescale 1ns/1ps
package fb_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_BUF_NUM    = 3;
  localparam int DEF_IDX_BITS   = 2;
  localparam int DEF_CNT_BITS   = 16;

endpackage

// File: rtl/fb_next_idx.sv
// Picks the writer's next buffer: round-robin successor, skipping the buffer the reader holds.
`timescale 1ns/1ps
module fb_next_idx
  import fb_sched_pkg::*;
#(
  parameter int C_BUF_NUM  = DEF_BUF_NUM,
  parameter int C_IDX_BITS = DEF_IDX_BITS
) (
  input  logic [C_IDX_BITS-1:0] w_idx,
  input  logic [C_IDX_BITS-1:0] r_idx,
  output logic [C_IDX_BITS-1:0] next
);

  localparam logic [C_IDX_BITS-1:0] LAST = C_IDX_BITS'(C_BUF_NUM - 1);

  function automatic logic [C_IDX_BITS-1:0] wrap_inc(input logic [C_IDX_BITS-1:0] i);
    return (i == LAST) ? '0 : i + C_IDX_BITS'(1);
  endfunction

  logic [C_IDX_BITS-1:0] step1;

  // With at least three buffers a single extra step always clears the reader.
  always_comb begin
    step1 = wrap_inc(w_idx);
    next  = (step1 == r_idx) ? wrap_inc(step1) : step1;
  end

endmodule

// File: rtl/fb_buf_sched.sv
// Triple/quad frame-buffer scheduler: writer never lands on the buffer the reader holds.
// Optional statistics counters are built only when FB_SCHED_STATS_EN is defined.
`timescale 1ns/1ps
module fb_buf_sched
  import fb_sched_pkg::*;
#(
  parameter int C_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int C_BUF_NUM    = DEF_BUF_NUM,
  parameter int C_IDX_BITS   = DEF_IDX_BITS,
  parameter int C_CNT_BITS   = DEF_CNT_BITS
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              soft_resetn,
  output logic                              resetting,
  input  logic [C_BUF_NUM*C_ADDR_WIDTH-1:0] buf_addr,
  input  logic                              s2mm_sof,
  output logic [C_IDX_BITS-1:0]             s2mm_idx,
  output logic [C_ADDR_WIDTH-1:0]           s2mm_addr,
  input  logic                              mm2s_sof,
  output logic [C_IDX_BITS-1:0]             mm2s_idx,
  output logic [C_ADDR_WIDTH-1:0]           mm2s_addr,
  output logic                              mm2s_valid,
  output logic [C_CNT_BITS-1:0]             wr_frame_cnt,
  output logic [C_CNT_BITS-1:0]             drop_cnt,
  output logic [C_CNT_BITS-1:0]             repeat_cnt
);

  state_t                state;
  logic [C_IDX_BITS-1:0] w_idx;
  logic [C_IDX_BITS-1:0] r_idx;
  logic [C_IDX_BITS-1:0] latest;
  logic [C_IDX_BITS-1:0] eff_r;
  logic [C_IDX_BITS-1:0] next_w;
  logic                  latest_valid;
  logic                  consumed;
  logic                  rd_take;

  function automatic logic [C_ADDR_WIDTH-1:0] sel_addr(input logic [C_IDX_BITS-1:0] idx);
    return buf_addr[int'(idx)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
  endfunction

  // The reader grabs the pre-update latest, so the writer must avoid that one.
  assign rd_take = (state == RUN) & mm2s_sof & latest_valid;
  assign eff_r   = rd_take ? latest : r_idx;

  fb_next_idx #(
    .C_BUF_NUM  (C_BUF_NUM),
    .C_IDX_BITS (C_IDX_BITS)
  ) u_next (
    .w_idx (w_idx),
    .r_idx (eff_r),
    .next  (next_w)
  );

  assign s2mm_idx = w_idx;
  assign mm2s_idx = r_idx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      resetting    <= 1'b1;
      w_idx        <= '0;
      r_idx        <= '0;
      latest       <= '0;
      latest_valid <= 1'b0;
      consumed     <= 1'b0;
      mm2s_valid   <= 1'b0;
      s2mm_addr    <= '0;
      mm2s_addr    <= '0;
    end else begin
      s2mm_addr <= sel_addr(w_idx);
      mm2s_addr <= sel_addr(r_idx);
      if (!soft_resetn) begin
        state        <= IDLE;
        resetting    <= 1'b1;
        w_idx        <= '0;
        r_idx        <= '0;
        latest       <= '0;
        latest_valid <= 1'b0;
        consumed     <= 1'b0;
        mm2s_valid   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (s2mm_sof) begin
              state     <= RUN;
              resetting <= 1'b0;
            end
          end
          RUN: begin
            if (rd_take) begin
              r_idx      <= latest;
              mm2s_valid <= 1'b1;
              consumed   <= 1'b1;
            end
            // A fresh frame supersedes whatever the reader just took.
            if (s2mm_sof) begin
              latest       <= w_idx;
              latest_valid <= 1'b1;
              consumed     <= 1'b0;
              w_idx        <= next_w;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FB_SCHED_STATS_EN
  logic run_live;
  logic wr_ev;
  logic drop_ev;
  logic rep_ev;

  function automatic logic [C_CNT_BITS-1:0] sat_inc(input logic [C_CNT_BITS-1:0] c);
    return (&c) ? c : c + C_CNT_BITS'(1);
  endfunction

  assign run_live = (state == RUN) & soft_resetn;
  assign wr_ev    = run_live & s2mm_sof;
  assign drop_ev  = wr_ev & latest_valid & ~consumed & ~mm2s_sof;
  assign rep_ev   = run_live & mm2s_sof & mm2s_valid & (latest == r_idx);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_frame_cnt <= '0;
      drop_cnt     <= '0;
      repeat_cnt   <= '0;
    end else begin
      if (wr_ev)   wr_frame_cnt <= sat_inc(wr_frame_cnt);
      if (drop_ev) drop_cnt     <= sat_inc(drop_cnt);
      if (rep_ev)  repeat_cnt   <= sat_inc(repeat_cnt);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = consumed;
  assign wr_frame_cnt = '0;
  assign drop_cnt     = '0;
  assign repeat_cnt   = '0;
`endif

endmodule
